// File: rtl/remap_lut_bank.sv
// Remap look-up table: one host write port, N_RD registered read channels and a
// sweep engine that fills every entry with zero or identity contents.
module remap_lut_bank #(
    parameter int DATA_W          = 7,
    parameter int ADDR_W          = 7,
    parameter int N_RD            = 2,
    parameter bit RESET_INIT_MODE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_req,
    input  logic                     init_mode,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_valid,
    output logic                     busy,
    input  logic                     clr_drop,
    output logic [7:0]               drop_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                mode_q, mode_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic [DATA_W-1:0]   lut_mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   ident_fill;
    logic                drop;

    assign busy       = (state_q == INIT);
    assign drop_cnt   = drop_cnt_q;
    assign ident_fill = DATA_W'(idx_q);

    // A host write loses to the sweep and to a same-cycle sweep request.
    assign drop = wr_en && (busy || init_req);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = mode_q ? ident_fill : '0;
                idx_d     = idx_q + 1'b1;
                if (&idx_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (init_req) begin
                    state_d = INIT;
                    idx_d   = '0;
                    mode_d  = init_mode;
                end else if (wr_en) begin
                    mem_we = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_drop) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != 8'hff)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            idx_q      <= '0;
            mode_q     <= RESET_INIT_MODE;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            lut_mem[mem_waddr] <= mem_wdata;
        end
    end

    // Reads sample the array before this edge's write lands (read-first).
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
        logic [DATA_W-1:0] data_q, data_d;
        logic              valid_q, valid_d;

        always_comb begin
            data_d  = data_q;
            valid_d = 1'b0;
            if (rd_en[gi] && !busy) begin
                data_d  = lut_mem[rd_addr[gi*ADDR_W +: ADDR_W]];
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = data_q;
        assign rd_valid[gi]                 = valid_q;
    end
endmodule

// File: tb/tb_remap_lut_bank.sv
// Directed bench for remap_lut_bank: default instance plus a narrow 4-channel
// instance; read results are matched against a queue of expected entries.
module tb_remap_lut_bank;
    localparam int AW  = 7;
    localparam int DW  = 7;
    localparam int NR  = 2;
    localparam int BAW = 4;
    localparam int BDW = 3;
    localparam int BNR = 4;

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;
    int   n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              a_rst, a_init_req, a_init_mode, a_wr_en, a_clr_drop, a_busy;
    logic [AW-1:0]     a_wr_addr;
    logic [DW-1:0]     a_wr_data;
    logic [NR-1:0]     a_rd_en, a_rd_valid;
    logic [NR*AW-1:0]  a_rd_addr;
    logic [NR*DW-1:0]  a_rd_data;
    logic [7:0]        a_drop_cnt;

    logic              b_rst, b_init_req, b_init_mode, b_wr_en, b_clr_drop, b_busy;
    logic [BAW-1:0]    b_wr_addr;
    logic [BDW-1:0]    b_wr_data;
    logic [BNR-1:0]    b_rd_en, b_rd_valid;
    logic [BNR*BAW-1:0] b_rd_addr;
    logic [BNR*BDW-1:0] b_rd_data;
    logic [7:0]        b_drop_cnt;

    remap_lut_bank dut_a (
        .clk(clk), .reset(a_rst), .init_req(a_init_req), .init_mode(a_init_mode),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .busy(a_busy), .clr_drop(a_clr_drop), .drop_cnt(a_drop_cnt)
    );

    remap_lut_bank #(.DATA_W(BDW), .ADDR_W(BAW), .N_RD(BNR), .RESET_INIT_MODE(1'b1)) dut_b (
        .clk(clk), .reset(b_rst), .init_req(b_init_req), .init_mode(b_init_mode),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .busy(b_busy), .clr_drop(b_clr_drop), .drop_cnt(b_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wait_idle(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (a_busy && cnt < 400);
    endtask

    task automatic a_rd(input int c, input int addr, input int ex);
        a_rd_en[c] = 1'b1;
        a_rd_addr[c*AW +: AW] = addr[AW-1:0];
        qa.push_back('{c, ex});
    endtask

    task automatic b_rd(input int c, input int addr, input int ex);
        b_rd_en[c] = 1'b1;
        b_rd_addr[c*BAW +: BAW] = addr[BAW-1:0];
        qb.push_back('{c, ex});
    endtask

    task automatic a_drain();
        exp_t e;
        for (int c = 0; c < NR; c++) begin
            if (a_rd_valid[c]) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_valid", qa.size(), 1);
                end else begin
                    e = qa.pop_front();
                    chk("a_read_channel", c, e.ch);
                    chk("a_read_data", a_rd_data[c*DW +: DW], e.data);
                end
            end
        end
        chk("a_missing_valid", qa.size(), 0);
        qa.delete();
        a_rd_en = '0;
    endtask

    task automatic b_drain();
        exp_t e;
        for (int c = 0; c < BNR; c++) begin
            if (b_rd_valid[c]) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_valid", qb.size(), 1);
                end else begin
                    e = qb.pop_front();
                    chk("b_read_channel", c, e.ch);
                    chk("b_read_data", b_rd_data[c*BDW +: BDW], e.data);
                end
            end
        end
        chk("b_missing_valid", qb.size(), 0);
        qb.delete();
        b_rd_en = '0;
    endtask

    initial begin
        a_rst = 1'b1; a_init_req = 1'b0; a_init_mode = 1'b0; a_wr_en = 1'b0; a_clr_drop = 1'b0;
        a_wr_addr = '0; a_wr_data = '0; a_rd_en = '0; a_rd_addr = '0;
        b_rst = 1'b1; b_init_req = 1'b0; b_init_mode = 1'b0; b_wr_en = 1'b0; b_clr_drop = 1'b0;
        b_wr_addr = '0; b_wr_data = '0; b_rd_en = '0; b_rd_addr = '0;
        repeat (2) tick();

        // Reset state
        chk("a_reset_busy", a_busy, 1);
        chk("a_reset_valid", a_rd_valid, 0);
        chk("a_reset_data", a_rd_data, 0);
        chk("a_reset_drop", a_drop_cnt, 0);
        chk("b_reset_busy", b_busy, 1);
        chk("b_reset_valid", b_rd_valid, 0);

        // 1: post-reset identity sweep, reads issued as busy falls
        a_rst = 1'b0;
        a_wait_idle(n);
        chk("a_reset_sweep_len", n, 128);
        a_rd(0, 0, 0);   a_rd(1, 127, 127); tick(); a_drain();
        a_rd(0, 5, 5);   a_rd(1, 64, 64);   tick(); a_drain();
        a_rd(0, 127, 127);                  tick(); a_drain();
        tick();
        chk("a_valid_pulse", a_rd_valid, 0);
        chk("a_hold_data", a_rd_data, {7'd64, 7'd127});

        // 2: host write, dual-channel read, read-first collision
        a_wr_en = 1'b1; a_wr_addr = 7'd10; a_wr_data = 7'h55; tick(); a_wr_en = 1'b0;
        a_rd(0, 10, 'h55); a_rd(1, 10, 'h55); tick(); a_drain();
        a_wr_en = 1'b1; a_wr_addr = 7'd10; a_wr_data = 7'h22;
        a_rd(0, 10, 'h55); tick(); a_wr_en = 1'b0; a_drain();
        a_rd(1, 10, 'h22); tick(); a_drain();

        // 3: zero sweep with dropped writes, ignored re-request, blocked read
        a_init_mode = 1'b0; a_init_req = 1'b1; tick(); a_init_req = 1'b0;
        chk("a_req_busy", a_busy, 1);
        n = 0;
        do begin
            a_wr_en = (n == 3 || n == 4 || n == 90);
            a_wr_addr = n[AW-1:0]; a_wr_data = 7'h7f;
            a_init_req = (n == 60); a_init_mode = 1'b1;
            if (n == 20) begin
                a_rd_en = 2'b11; a_rd_addr = {7'd3, 7'd3};
            end
            tick();
            n++;
            if (n == 21) begin
                chk("a_busy_read_valid", a_rd_valid, 0);
                chk("a_busy_read_hold", a_rd_data, {7'h22, 7'h55});
            end
            a_rd_en = '0;
        end while (a_busy && n < 400);
        a_wr_en = 1'b0; a_init_req = 1'b0;
        chk("a_zero_sweep_len", n, 128);
        chk("a_drop_three", a_drop_cnt, 3);
        for (int i = 0; i < 64; i++) begin
            a_rd(0, 2*i, 0); a_rd(1, 2*i + 1, 0); tick(); a_drain();
        end

        // 4: init wins over write, saturation, clear beats drop
        a_init_mode = 1'b1; a_init_req = 1'b1; a_wr_en = 1'b1; a_wr_addr = 7'd1;
        tick(); a_init_req = 1'b0; a_wr_en = 1'b0;
        chk("a_init_write_drop", a_drop_cnt, 4);
        for (int i = 0; i < 300; i++) begin
            a_wr_en = 1'b1; a_init_req = !a_busy;
            tick();
        end
        a_wr_en = 1'b0; a_init_req = 1'b0;
        chk("a_drop_saturate", a_drop_cnt, 255);
        a_wait_idle(n);
        chk("a_idle_after_flood", a_busy, 0);
        a_init_req = 1'b1; a_wr_en = 1'b1; a_clr_drop = 1'b1;
        tick(); a_init_req = 1'b0; a_wr_en = 1'b0; a_clr_drop = 1'b0;
        chk("a_clear_beats_drop", a_drop_cnt, 0);
        a_wr_en = 1'b1; tick(); a_wr_en = 1'b0;
        chk("a_drop_after_clear", a_drop_cnt, 1);
        a_wait_idle(n);
        a_rd(0, 100, 100); a_rd(1, 127, 127); tick(); a_drain();

        // 5: reset in the middle of a requested zero sweep
        a_init_mode = 1'b0; a_init_req = 1'b1; a_wr_en = 1'b1;
        tick(); a_init_req = 1'b0; a_wr_en = 1'b0;
        chk("a_drop_pre_reset", a_drop_cnt, 2);
        repeat (40) tick();
        #2 a_rst = 1'b1;
        #1;
        chk("a_async_busy", a_busy, 1);
        chk("a_async_valid", a_rd_valid, 0);
        chk("a_async_data", a_rd_data, 0);
        chk("a_async_drop", a_drop_cnt, 0);
        tick();
        a_rst = 1'b0;
        a_wait_idle(n);
        chk("a_rerun_sweep_len", n, 128);
        a_rd(0, 100, 100); a_rd(1, 20, 20); tick(); a_drain();

        // 6: narrow instance, truncated identity, four concurrent channels
        b_rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (b_busy && n < 100);
        chk("b_sweep_len", n, 16);
        b_rd(0, 9, 1); b_rd(1, 3, 3); b_rd(2, 15, 7); b_rd(3, 12, 4); tick(); b_drain();
        b_rd(0, 9, 1); b_rd(1, 10, 2); b_rd(2, 0, 0); b_rd(3, 7, 7);  tick(); b_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/remap_lut_bank.md
Name: remap_lut_bank

Overview:
Parametrised remap look-up table: DEPTH = 2^ADDR_W entries of DATA_W bits, one host write port and N_RD independent registered read channels. A sequenced initialisation engine sweeps the table, one entry per cycle, with zero or identity contents. It runs automatically after reset and on request. Sits behind the okClk-domain wire/trigger endpoints as the next-generation channel remap table, feeding readback wire-outs and downstream channel muxes.

Parameters:
DATA_W, 7, entry width in bits
ADDR_W, 7, address width; DEPTH = 2^ADDR_W
N_RD, 2, number of read channels (>=1)
RESET_INIT_MODE, 1, fill used by the post-reset sweep: 0 = zero, 1 = identity

Ports:
clk  in  1  single clock (okClk domain)
reset  in  1  asynchronous, active-high reset
init_req  in  1  single-cycle pulse; starts an init sweep
init_mode  in  1  fill for a requested sweep (0 zero, 1 identity); sampled with init_req
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  N_RD  per-channel read strobe
rd_addr  in  N_RD*ADDR_W  channel c address at [c*ADDR_W +: ADDR_W]
rd_data  out  N_RD*DATA_W  channel c data at [c*DATA_W +: DATA_W], registered
rd_valid  out  N_RD  per-channel data-valid, one-cycle pulse
busy  out  1  high while an init sweep runs
clr_drop  in  1  synchronous clear of drop_cnt
drop_cnt  out  8  saturating count of rejected writes

Behaviour:
- Reset: asynchronous. On assertion: state = INIT, idx = 0, mode = RESET_INIT_MODE, busy = 1, rd_data = 0, rd_valid = 0, drop_cnt = 0. Table storage has no reset and is overwritten by the sweep.
- FSM states: IDLE, INIT.
- INIT:
  - Each cycle, write entry idx with the fill value: 0, or idx zero-extended/truncated to DATA_W for identity. Then increment idx.
  - On the cycle the entry at idx = DEPTH-1 is written, move to IDLE. busy drops on the next cycle.
  - After reset release, busy stays high for exactly DEPTH clk edges.
- IDLE + init_req=1:
  - Latch init_mode, idx = 0, move to INIT. busy = 1 from the next cycle.
  - The sweep lasts DEPTH cycles, with the first entry written on the following edge.
- init_req while busy: ignored; the sweep does not restart, and init_mode is not re-sampled.
- Writes:
  - In IDLE with no init_req, wr_en=1 writes wr_data to wr_addr at the clock edge.
  - A write is dropped if wr_en=1 while busy=1, or together with init_req in IDLE (init wins).
  - Each dropped write increments drop_cnt by 1, saturating at 255.
  - clr_drop=1 zeroes drop_cnt. If clr_drop and a drop occur in the same cycle, the result is 0.
- Reads:
  - Latency 1. With rd_en[c]=1 and busy=0 at edge k, rd_data[c] = table[rd_addr[c]] and rd_valid[c] = 1 after edge k.
  - rd_valid[c] returns to 0 on the next edge unless rd_en[c] is held high. Continuous rd_en gives one result per cycle.
  - With rd_en[c]=1 while busy=1: rd_valid[c] = 0 and rd_data[c] holds its previous value.
  - rd_data holds its value whenever rd_valid is 0.
  - All channels are independent; identical addresses on several channels are legal.
- Read/write same address, same edge: read-first, i.e. rd_data returns the pre-write contents. The new value is visible from the next read.
- Reads may be issued in the cycle busy falls and return post-sweep contents.
- Reset mid-sweep or mid-operation: restart the reset sweep from idx 0 with RESET_INIT_MODE. Partial table contents are don't-care until the sweep completes.
- No combinational path from any input to any output.

Test Plan:
1. Release reset (RESET_INIT_MODE=1, defaults). Expect busy high for exactly 128 cycles. Then read addresses 0, 5, 127 on ch0 and 127, 64 on ch1: data 0, 5, 127 / 127, 64, each with rd_valid one cycle after rd_en.
2. IDLE: write addr 10 = 7'h55, then read ch0 addr 10 and ch1 addr 10 simultaneously. Both return 7'h55 with latency 1. In the same cycle as a write of 7'h22 to addr 10, a read of addr 10 returns 7'h55; the next read returns 7'h22.
3. Pulse init_req with init_mode=0, then issue 3 writes during the sweep. Expect busy for 128 cycles, drop_cnt = 3, and all addresses read 0 afterwards; reads during busy give rd_valid = 0.
4. Issue init_req and wr_en in the same IDLE cycle: the write is dropped and drop_cnt increments. Issue 300 busy writes: drop_cnt saturates at 255. clr_drop then gives 0.
5. Assert reset at sweep idx 40 of a requested zero sweep. Expect all outputs reset immediately and a full 128-cycle identity sweep after release; addr 100 reads 100.
6. Regressions at ADDR_W=4, DATA_W=3, N_RD=4:
   - busy lasts 16 cycles.
   - Identity fill truncates: addr 9 reads 1.
   - All 4 channels read distinct addresses concurrently and each returns the correct value.
